shift_reg_arbiter: RTL

Round-robin controller that shares one serial-in/parallel-out shift register among NREQ requesters. It grants one requester and latches that requester's WIDTH-bit word. It then clears the shift register, shifts the word in MSB-first with an enable, and captures the register's parallel output. The captured value is returned on result_o with a per-requester done pulse. It sits between requester logic and a Shift_Register-style datapath; the shift register is instantiated alongside this block, not inside it.

---
 rtl/shift_reg_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter that shares one external serial-in/parallel-out shift register
// among NREQ requesters. Optional loopback check enabled by macro SRARB_LOOPBACK_CHK_EN.
module shift_reg_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic [WIDTH-1:0]      result_o,
  output logic                  busy_o,
`ifdef SRARB_LOOPBACK_CHK_EN
  output logic                  err_o,
`endif
  output logic                  sr_clr_o,
  output logic                  sr_en_o,
  output logic                  sr_x_o,
  input  logic [WIDTH-1:0]      sr_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0  = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  last_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WIDTH-1:0]  shadow_reg;

  logic [WIDTH-1:0]  data_slice [NREQ];
  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  next_bit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_slice[gi] = data_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search upward from last+1, wrapping, so the most recently served requester is last.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_reg) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!win_valid && req_i[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign cnt_next = cnt_reg + CNT_W'(1);
  assign next_bit = CNT_LAST - cnt_next;

  // last_reg doubles as the owner of the transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      last_reg   <= LAST_INIT;
      cnt_reg    <= '0;
      shadow_reg <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      result_o   <= '0;
      busy_o     <= 1'b0;
      sr_clr_o   <= 1'b0;
      sr_en_o    <= 1'b0;
      sr_x_o     <= 1'b0;
`ifdef SRARB_LOOPBACK_CHK_EN
      err_o      <= 1'b0;
`endif
    end else begin
      gnt_o    <= '0;
      done_o   <= '0;
      sr_clr_o <= 1'b0;
`ifdef SRARB_LOOPBACK_CHK_EN
      err_o    <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            shadow_reg <= data_slice[win_idx];
            last_reg   <= win_idx;
            gnt_o      <= ONE_HOT0 << win_idx;
            sr_clr_o   <= 1'b1;
            busy_o     <= 1'b1;
            state_reg  <= LOAD;
          end
        end
        LOAD: begin
          cnt_reg   <= '0;
          sr_en_o   <= 1'b1;
          sr_x_o    <= shadow_reg[WIDTH-1];
          state_reg <= SHIFT;
        end
        SHIFT: begin
          if (cnt_reg == CNT_LAST) begin
            sr_en_o   <= 1'b0;
            sr_x_o    <= 1'b0;
            state_reg <= CAPTURE;
          end else begin
            cnt_reg <= cnt_next;
            sr_x_o  <= shadow_reg[next_bit];
          end
        end
        CAPTURE: begin
          result_o  <= sr_i;
          done_o    <= ONE_HOT0 << last_reg;
          busy_o    <= 1'b0;
`ifdef SRARB_LOOPBACK_CHK_EN
          err_o     <= (sr_i != shadow_reg);
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
